// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings and the control bundle for the RV32I decode stage.
// The decoder fills ctrl_t; the ID/EX register stores it unchanged.
package rv32_ctrl_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_OPB  = 5'd10;
    localparam logic [4:0] ALU_MUL  = 5'd11;

    localparam logic [1:0] WB_PC4 = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_LSU = 2'b10;

    localparam logic OPA_RS1 = 1'b0;
    localparam logic OPA_PC  = 1'b1;
    localparam logic OPB_RS2 = 1'b0;
    localparam logic OPB_IMM = 1'b1;

    typedef struct packed {
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_rden;
        logic       br_un;
        logic       opa_sel;
        logic       opb_sel;
        logic       is_br;
        logic       is_jal;
        logic       is_jalr;
        logic [4:0] alu_op;
        logic [1:0] wb_sel;
        logic       insn_vld;
    } ctrl_t;

    // Base-ISA ALU op selected by funct3 alone (shift-right defaults to logical).
    function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I(+M) control decoder: instruction word to ctrl_t.
// Illegal encodings produce an all-zero bundle with insn_vld low.
module rv32_decoder
    import rv32_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  logic [31:0] inst,
    output ctrl_t       ctrl
);

    logic [4:0] opcode_s;
    logic [2:0] f3_s;
    logic [6:0] f7_s;
    logic       legal_s;
    ctrl_t      raw_s;
    logic       unused_s;

    assign opcode_s = inst[6:2];
    assign f3_s     = inst[14:12];
    assign f7_s     = inst[31:25];
    assign unused_s = ^inst[24:15];

    // Per-opcode control fields and legality check.
    always_comb begin
        raw_s   = '0;
        legal_s = 1'b0;
        if (inst[1:0] == 2'b11) begin
            case (opcode_s)
                OPC_LUI: begin
                    legal_s        = 1'b1;
                    raw_s.rd_wren  = 1'b1;
                    raw_s.opb_sel  = OPB_IMM;
                    raw_s.alu_op   = ALU_OPB;
                    raw_s.wb_sel   = WB_ALU;
                end
                OPC_AUIPC: begin
                    legal_s        = 1'b1;
                    raw_s.rd_wren  = 1'b1;
                    raw_s.opa_sel  = OPA_PC;
                    raw_s.opb_sel  = OPB_IMM;
                    raw_s.alu_op   = ALU_ADD;
                    raw_s.wb_sel   = WB_ALU;
                end
                OPC_JAL: begin
                    legal_s        = 1'b1;
                    raw_s.rd_wren  = 1'b1;
                    raw_s.opa_sel  = OPA_PC;
                    raw_s.opb_sel  = OPB_IMM;
                    raw_s.alu_op   = ALU_ADD;
                    raw_s.wb_sel   = WB_PC4;
                    raw_s.is_jal   = 1'b1;
                end
                OPC_JALR: begin
                    legal_s        = (f3_s == F3_ADD);
                    raw_s.rs1_en   = 1'b1;
                    raw_s.rd_wren  = 1'b1;
                    raw_s.opa_sel  = OPA_RS1;
                    raw_s.opb_sel  = OPB_IMM;
                    raw_s.alu_op   = ALU_ADD;
                    raw_s.wb_sel   = WB_PC4;
                    raw_s.is_jalr  = 1'b1;
                end
                OPC_BRANCH: begin
                    case (f3_s)
                        3'b010, 3'b011: legal_s = 1'b0;
                        default:        legal_s = 1'b1;
                    endcase
                    raw_s.rs1_en   = 1'b1;
                    raw_s.rs2_en   = 1'b1;
                    raw_s.opa_sel  = OPA_PC;
                    raw_s.opb_sel  = OPB_IMM;
                    raw_s.alu_op   = ALU_ADD;
                    raw_s.is_br    = 1'b1;
                    raw_s.br_un    = (f3_s == F3_BLTU) | (f3_s == F3_BGEU);
                end
                OPC_LOAD: begin
                    case (f3_s)
                        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                        default:                                legal_s = 1'b0;
                    endcase
                    raw_s.rs1_en   = 1'b1;
                    raw_s.rd_wren  = 1'b1;
                    raw_s.mem_rden = 1'b1;
                    raw_s.opb_sel  = OPB_IMM;
                    raw_s.alu_op   = ALU_ADD;
                    raw_s.wb_sel   = WB_LSU;
                end
                OPC_STORE: begin
                    case (f3_s)
                        3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                        default:                legal_s = 1'b0;
                    endcase
                    raw_s.rs1_en   = 1'b1;
                    raw_s.rs2_en   = 1'b1;
                    raw_s.mem_wren = 1'b1;
                    raw_s.opb_sel  = OPB_IMM;
                    raw_s.alu_op   = ALU_ADD;
                end
                OPC_OP_IMM: begin
                    raw_s.rs1_en   = 1'b1;
                    raw_s.rd_wren  = 1'b1;
                    raw_s.opb_sel  = OPB_IMM;
                    raw_s.wb_sel   = WB_ALU;
                    case (f3_s)
                        F3_SLL: begin
                            legal_s      = (f7_s == F7_BASE);
                            raw_s.alu_op = ALU_SLL;
                        end
                        F3_SR: begin
                            legal_s      = (f7_s == F7_BASE) | (f7_s == F7_ALT);
                            raw_s.alu_op = (f7_s == F7_ALT) ? ALU_SRA : ALU_SRL;
                        end
                        default: begin
                            legal_s      = 1'b1;
                            raw_s.alu_op = alu_from_funct3(f3_s);
                        end
                    endcase
                end
                OPC_OP: begin
                    raw_s.rs1_en   = 1'b1;
                    raw_s.rs2_en   = 1'b1;
                    raw_s.rd_wren  = 1'b1;
                    raw_s.opb_sel  = OPB_RS2;
                    raw_s.wb_sel   = WB_ALU;
                    if (f7_s == F7_BASE) begin
                        legal_s      = 1'b1;
                        raw_s.alu_op = alu_from_funct3(f3_s);
                    end else if (f7_s == F7_ALT) begin
                        case (f3_s)
                            F3_ADD: begin
                                legal_s      = 1'b1;
                                raw_s.alu_op = ALU_SUB;
                            end
                            F3_SR: begin
                                legal_s      = 1'b1;
                                raw_s.alu_op = ALU_SRA;
                            end
                            default: legal_s = 1'b0;
                        endcase
                    end else if (EN_M && (f7_s == F7_MEXT)) begin
                        legal_s      = 1'b1;
                        raw_s.alu_op = ALU_MUL + {2'b00, f3_s};
                    end else begin
                        legal_s = 1'b0;
                    end
                end
                default: legal_s = 1'b0;
            endcase
        end else begin
            legal_s = 1'b0;
        end
    end

    // Writes to x0 are suppressed here so downstream never sees a live x0 write.
    always_comb begin
        ctrl = '0;
        if (legal_s) begin
            ctrl          = raw_s;
            ctrl.insn_vld = 1'b1;
            ctrl.rd_wren  = raw_s.rd_wren & (inst[11:7] != 5'd0);
        end else begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered ID->EX decode stage: decoder, ID/EX register, load-use bubble
// insertion with a saturating stall counter, and flush on redirect.
module decode_ctrl_stage
    import rv32_ctrl_pkg::*;
#(
    parameter bit EN_M     = 1'b0,
    parameter int ALU_OP_W = 5,
    parameter int CNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [31:0]         i_inst,
    input  logic [31:0]         i_pc,
    input  logic                i_flush,
    input  logic                i_ex_ready,
    output logic                o_valid,
    output logic [31:0]         o_pc,
    output logic [4:0]          o_rs1,
    output logic [4:0]          o_rs2,
    output logic [4:0]          o_rd,
    output logic [2:0]          o_funct3,
    output logic                o_rs1_en,
    output logic                o_rs2_en,
    output logic                o_rd_wren,
    output logic                o_mem_wren,
    output logic                o_mem_rden,
    output logic                o_br_un,
    output logic                o_opa_sel,
    output logic                o_opb_sel,
    output logic                o_is_br,
    output logic                o_is_jal,
    output logic                o_is_jalr,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic [1:0]          o_wb_sel,
    output logic                o_insn_vld,
    output logic [CNT_W-1:0]    o_stall_cnt
);

    generate
        if ((ALU_OP_W < 4) || (EN_M && (ALU_OP_W < 5))) begin : g_alu_op_w_check
            $error("decode_ctrl_stage: ALU_OP_W too narrow for the enabled ALU ops");
        end
    endgenerate

    ctrl_t            dec_ctrl_s;
    ctrl_t            ctrl_r;
    logic             valid_r;
    logic [31:0]      pc_r;
    logic [4:0]       rs1_r;
    logic [4:0]       rs2_r;
    logic [4:0]       rd_r;
    logic [2:0]       funct3_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic       advance_s;
    logic       hazard_s;
    logic       load_s;
    logic       take_s;
    logic       count_s;
    logic [4:0] dec_rs1_s;
    logic [4:0] dec_rs2_s;

    rv32_decoder #(
        .EN_M (EN_M)
    ) u_decoder (
        .inst (i_inst),
        .ctrl (dec_ctrl_s)
    );

    // Handshake: a load in ID/EX whose rd feeds the incoming instruction forces one bubble.
    always_comb begin
        dec_rs1_s = i_inst[19:15];
        dec_rs2_s = i_inst[24:20];
        advance_s = ~valid_r | i_ex_ready;
        hazard_s  = valid_r & ctrl_r.mem_rden & (rd_r != 5'd0) & i_valid &
                    ((dec_ctrl_s.rs1_en & (dec_rs1_s == rd_r)) |
                     (dec_ctrl_s.rs2_en & (dec_rs2_s == rd_r)));
        load_s    = i_flush | advance_s;
        take_s    = ~i_flush & ~hazard_s & advance_s & i_valid;
        count_s   = ~i_flush & hazard_s & advance_s & ~(&stall_cnt_r);
        o_ready   = i_rst_n & (i_flush | (advance_s & ~hazard_s));
    end

    // ID/EX register: loads the decoded instruction or a zeroed bubble, else holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r  <= 1'b0;
            pc_r     <= 32'd0;
            rs1_r    <= 5'd0;
            rs2_r    <= 5'd0;
            rd_r     <= 5'd0;
            funct3_r <= 3'd0;
            ctrl_r   <= '0;
        end else if (load_s) begin
            valid_r  <= take_s;
            pc_r     <= take_s ? i_pc : 32'd0;
            rs1_r    <= take_s ? i_inst[19:15] : 5'd0;
            rs2_r    <= take_s ? i_inst[24:20] : 5'd0;
            rd_r     <= take_s ? i_inst[11:7] : 5'd0;
            funct3_r <= take_s ? i_inst[14:12] : 3'd0;
            ctrl_r   <= take_s ? dec_ctrl_s : '0;
        end
    end

    // Saturating count of load-use bubbles; a flush in the same cycle is not a stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_r <= '0;
        end else if (count_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

    assign o_valid     = valid_r;
    assign o_pc        = pc_r;
    assign o_rs1       = rs1_r;
    assign o_rs2       = rs2_r;
    assign o_rd        = rd_r;
    assign o_funct3    = funct3_r;
    assign o_rs1_en    = ctrl_r.rs1_en;
    assign o_rs2_en    = ctrl_r.rs2_en;
    assign o_rd_wren   = ctrl_r.rd_wren;
    assign o_mem_wren  = ctrl_r.mem_wren;
    assign o_mem_rden  = ctrl_r.mem_rden;
    assign o_br_un     = ctrl_r.br_un;
    assign o_opa_sel   = ctrl_r.opa_sel;
    assign o_opb_sel   = ctrl_r.opb_sel;
    assign o_is_br     = ctrl_r.is_br;
    assign o_is_jal    = ctrl_r.is_jal;
    assign o_is_jalr   = ctrl_r.is_jalr;
    assign o_alu_op    = ALU_OP_W'(ctrl_r.alu_op);
    assign o_wb_sel    = ctrl_r.wb_sel;
    assign o_insn_vld  = ctrl_r.insn_vld;
    assign o_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Randomized + directed bench for decode_ctrl_stage; two instances (EN_M=0/CNT_W=16
// and EN_M=1/CNT_W=3) run against an instruction-level reference model.
module tb_decode_ctrl_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_wren;
        logic        mem_wren;
        logic        mem_rden;
        logic        br_un;
        logic        opa;
        logic        opb;
        logic        is_br;
        logic        is_jal;
        logic        is_jalr;
        logic [4:0]  alu;
        logic [1:0]  wb;
        logic        vld;
    } img_t;

    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD66 = 32'h00528333;
    localparam logic [31:0] MUL3  = 32'h022081B3;
    localparam logic [31:0] ADDI0 = 32'h00100013;

    logic clk = 1'b0;
    logic rst_n, in_valid, flush, ex_ready;
    logic [31:0] inst, pc;

    logic a_ready, a_valid, a_rs1_en, a_rs2_en, a_rd_wren, a_mem_wren, a_mem_rden, a_br_un;
    logic a_opa, a_opb, a_is_br, a_is_jal, a_is_jalr, a_vld;
    logic [31:0] a_pc;
    logic [4:0] a_rs1, a_rs2, a_rd, a_alu;
    logic [2:0] a_f3;
    logic [1:0] a_wb;
    logic [15:0] a_cnt;

    logic b_ready, b_valid, b_rs1_en, b_rs2_en, b_rd_wren, b_mem_wren, b_mem_rden, b_br_un;
    logic b_opa, b_opb, b_is_br, b_is_jal, b_is_jalr, b_vld;
    logic [31:0] b_pc;
    logic [4:0] b_rs1, b_rs2, b_rd, b_alu;
    logic [2:0] b_f3;
    logic [1:0] b_wb;
    logic [2:0] b_cnt;

    img_t obs_a, obs_b;
    img_t m_img [2];
    int unsigned m_cnt [2];
    logic m_rdy [2];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.EN_M(1'b0), .ALU_OP_W(5), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(a_ready),
        .i_inst(inst), .i_pc(pc), .i_flush(flush), .i_ex_ready(ex_ready),
        .o_valid(a_valid), .o_pc(a_pc), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_rd(a_rd),
        .o_funct3(a_f3), .o_rs1_en(a_rs1_en), .o_rs2_en(a_rs2_en), .o_rd_wren(a_rd_wren),
        .o_mem_wren(a_mem_wren), .o_mem_rden(a_mem_rden), .o_br_un(a_br_un),
        .o_opa_sel(a_opa), .o_opb_sel(a_opb), .o_is_br(a_is_br), .o_is_jal(a_is_jal),
        .o_is_jalr(a_is_jalr), .o_alu_op(a_alu), .o_wb_sel(a_wb), .o_insn_vld(a_vld),
        .o_stall_cnt(a_cnt)
    );

    decode_ctrl_stage #(.EN_M(1'b1), .ALU_OP_W(5), .CNT_W(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(b_ready),
        .i_inst(inst), .i_pc(pc), .i_flush(flush), .i_ex_ready(ex_ready),
        .o_valid(b_valid), .o_pc(b_pc), .o_rs1(b_rs1), .o_rs2(b_rs2), .o_rd(b_rd),
        .o_funct3(b_f3), .o_rs1_en(b_rs1_en), .o_rs2_en(b_rs2_en), .o_rd_wren(b_rd_wren),
        .o_mem_wren(b_mem_wren), .o_mem_rden(b_mem_rden), .o_br_un(b_br_un),
        .o_opa_sel(b_opa), .o_opb_sel(b_opb), .o_is_br(b_is_br), .o_is_jal(b_is_jal),
        .o_is_jalr(b_is_jalr), .o_alu_op(b_alu), .o_wb_sel(b_wb), .o_insn_vld(b_vld),
        .o_stall_cnt(b_cnt)
    );

    assign obs_a = {a_valid, a_pc, a_rs1, a_rs2, a_rd, a_f3, a_rs1_en, a_rs2_en, a_rd_wren,
                    a_mem_wren, a_mem_rden, a_br_un, a_opa, a_opb, a_is_br, a_is_jal,
                    a_is_jalr, a_alu, a_wb, a_vld};
    assign obs_b = {b_valid, b_pc, b_rs1, b_rs2, b_rd, b_f3, b_rs1_en, b_rs2_en, b_rd_wren,
                    b_mem_wren, b_mem_rden, b_br_un, b_opa, b_opb, b_is_br, b_is_jal,
                    b_is_jalr, b_alu, b_wb, b_vld};

    task automatic check(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int unsigned cnt_max(input int k);
        return (k == 0) ? 32'd65535 : 32'd7;
    endfunction

    // Instruction-level meaning of a word, straight from the ISA rules.
    function automatic img_t ref_decode(input logic [31:0] w, input logic [31:0] p, input bit en_m);
        img_t r;
        img_t z;
        bit ok;
        int f3;
        int f7;
        int base_tab [8];
        base_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        r = '0;
        r.valid = 1'b1;
        r.pc = p;
        r.rs1 = w[19:15];
        r.rs2 = w[24:20];
        r.rd = w[11:7];
        r.f3 = w[14:12];
        z = r;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        ok = 1'b0;
        if (w[1:0] == 2'b11) begin
            case (w[6:2])
                5'b01101: begin ok = 1'b1; r.rd_wren = 1'b1; r.opb = 1'b1; r.alu = 5'd10; r.wb = 2'd1; end
                5'b00101: begin ok = 1'b1; r.rd_wren = 1'b1; r.opa = 1'b1; r.opb = 1'b1; r.wb = 2'd1; end
                5'b11011: begin ok = 1'b1; r.rd_wren = 1'b1; r.opa = 1'b1; r.opb = 1'b1; r.is_jal = 1'b1; end
                5'b11001: begin
                    ok = (f3 == 0); r.rs1_en = 1'b1; r.rd_wren = 1'b1; r.opb = 1'b1; r.is_jalr = 1'b1;
                end
                5'b11000: begin
                    ok = (f3 != 2) && (f3 != 3);
                    r.rs1_en = 1'b1; r.rs2_en = 1'b1; r.opa = 1'b1; r.opb = 1'b1; r.is_br = 1'b1;
                    r.br_un = (f3 >= 6);
                end
                5'b00000: begin
                    ok = (f3 <= 2) || (f3 == 4) || (f3 == 5);
                    r.rs1_en = 1'b1; r.rd_wren = 1'b1; r.mem_rden = 1'b1; r.opb = 1'b1; r.wb = 2'd2;
                end
                5'b01000: begin
                    ok = (f3 <= 2); r.rs1_en = 1'b1; r.rs2_en = 1'b1; r.mem_wren = 1'b1; r.opb = 1'b1;
                end
                5'b00100: begin
                    r.rs1_en = 1'b1; r.rd_wren = 1'b1; r.opb = 1'b1; r.wb = 2'd1;
                    if (f3 == 1) begin
                        ok = (f7 == 0); r.alu = 5'd2;
                    end else if (f3 == 5) begin
                        ok = (f7 == 0) || (f7 == 32); r.alu = (f7 == 32) ? 5'd7 : 5'd6;
                    end else begin
                        ok = 1'b1; r.alu = 5'(base_tab[f3]);
                    end
                end
                5'b01100: begin
                    r.rs1_en = 1'b1; r.rs2_en = 1'b1; r.rd_wren = 1'b1; r.wb = 2'd1;
                    if (f7 == 0) begin
                        ok = 1'b1; r.alu = 5'(base_tab[f3]);
                    end else if (f7 == 32) begin
                        ok = (f3 == 0) || (f3 == 5); r.alu = (f3 == 0) ? 5'd1 : 5'd7;
                    end else if ((f7 == 1) && en_m) begin
                        ok = 1'b1; r.alu = 5'(11 + f3);
                    end
                end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            r = z;
        end else begin
            r.vld = 1'b1;
            if (r.rd == 5'd0) r.rd_wren = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs1, rs2, rd;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] rnd;
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7));
        rnd = $urandom;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = rnd[31:25];
        endcase
        case ($urandom_range(0, 11))
            0, 10, 11: return {rnd[31:20], rs1, f3, rd, 7'b0000011};
            1: return {rnd[31:25], rs2, rs1, f3, rnd[11:7], 7'b0100011};
            2: return {f7, rs2, rs1, f3, rd, 7'b0010011};
            4: return {rnd[31:25], rs2, rs1, f3, rnd[11:7], 7'b1100011};
            5: return {rnd[31:12], rd, 7'b1101111};
            6: return {rnd[31:20], rs1, f3, rd, 7'b1100111};
            7: return {rnd[31:12], rd, 7'b0110111};
            8: return {rnd[31:12], rd, 7'b0010111};
            9: return rnd;
            default: return {f7, rs2, rs1, f3, rd, 7'b0110011};
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_img[k] = '0;
            m_cnt[k] = 0;
            m_rdy[k] = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_img_a"}, 80'(obs_a), 80'd0);
        check({tag, "_img_b"}, 80'(obs_b), 80'd0);
        check({tag, "_cnt_a"}, 80'(a_cnt), 80'd0);
        check({tag, "_cnt_b"}, 80'(b_cnt), 80'd0);
        check({tag, "_rdy_a"}, 80'(a_ready), 80'd0);
        check({tag, "_rdy_b"}, 80'(b_ready), 80'd0);
    endtask

    // One clock: drive at negedge, check ready, advance model at posedge, check registers.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic fl, input logic er);
        img_t nxt [2];
        int unsigned ncnt [2];
        img_t d;
        logic adv, haz, rdy;
        logic obs_rdy [2];
        @(negedge clk);
        in_valid = v; inst = ins; pc = p; flush = fl; ex_ready = er;
        #1;
        obs_rdy[0] = a_ready;
        obs_rdy[1] = b_ready;
        for (int k = 0; k < 2; k++) begin
            d = ref_decode(ins, p, k == 1);
            adv = !m_img[k].valid || er;
            haz = m_img[k].valid && m_img[k].mem_rden && (m_img[k].rd != 5'd0) && v &&
                  ((d.rs1_en && (d.rs1 == m_img[k].rd)) || (d.rs2_en && (d.rs2 == m_img[k].rd)));
            rdy = fl || (adv && !haz);
            check((k == 0) ? "ready_a" : "ready_b", 80'(obs_rdy[k]), 80'(rdy));
            m_rdy[k] = rdy;
            nxt[k] = m_img[k];
            ncnt[k] = m_cnt[k];
            if (fl) begin
                nxt[k] = '0;
            end else if (haz && adv) begin
                nxt[k] = '0;
                if (ncnt[k] < cnt_max(k)) ncnt[k] = ncnt[k] + 1;
            end else if (adv) begin
                nxt[k] = v ? d : '0;
            end
        end
        @(posedge clk);
        #1;
        m_img = nxt;
        m_cnt = ncnt;
        check("idex_a", 80'(obs_a), 80'(m_img[0]));
        check("idex_b", 80'(obs_b), 80'(m_img[1]));
        check("cnt_a", 80'(a_cnt), 80'(m_cnt[0]));
        check("cnt_b", 80'(b_cnt), 80'(m_cnt[1]));
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] pcv;
        logic v;
        logic hold;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; inst = 32'd0; pc = 32'd0;
        model_reset();
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, ADD3, 32'h100, 1'b0, 1'b1);
        check("add_alu", 80'(a_alu), 80'd0);
        check("add_rd", 80'(a_rd), 80'd3);
        check("add_wb", 80'(a_wb), 80'd1);
        check("add_wren", 80'(a_rd_wren), 80'd1);
        check("add_valid", 80'(a_valid), 80'd1);

        step(1'b1, LW5, 32'h104, 1'b0, 1'b1);
        step(1'b1, ADD66, 32'h108, 1'b0, 1'b1);
        check("lu_ready", 80'(m_rdy[0]), 80'd0);
        check("lu_bubble", 80'(a_valid), 80'd0);
        check("lu_cnt", 80'(a_cnt), 80'd1);
        step(1'b1, ADD66, 32'h108, 1'b0, 1'b1);
        check("lu_issue_rd", 80'(a_rd), 80'd6);

        step(1'b1, MUL3, 32'h10C, 1'b0, 1'b1);
        check("mul_m0_vld", 80'(a_vld), 80'd0);
        check("mul_m0_wren", 80'(a_rd_wren), 80'd0);
        check("mul_m1_alu", 80'(b_alu), 80'd11);

        step(1'b1, ADD3, 32'h110, 1'b1, 1'b1);
        check("flush_valid", 80'(a_valid), 80'd0);
        step(1'b1, LW5, 32'h114, 1'b0, 1'b1);
        step(1'b1, ADD66, 32'h118, 1'b1, 1'b1);
        check("flush_haz_cnt", 80'(a_cnt), 80'd1);

        step(1'b1, ADDI0, 32'h11C, 1'b0, 1'b1);
        check("x0_wren", 80'(a_rd_wren), 80'd0);
        check("x0_vld", 80'(a_vld), 80'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ADD3, 32'h120, 1'b0, 1'b0);
            check("exstall_ready", 80'(m_rdy[0]), 80'd0);
            check("exstall_pc", 80'(a_pc), 80'h11C);
        end
        step(1'b1, ADD3, 32'h120, 1'b0, 1'b1);

        step(1'b1, LW5, 32'h124, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; inst = ADD66; pc = 32'h128; flush = 1'b0; ex_ready = 1'b1;
        #1;
        check("mid_ready", 80'(a_ready), 80'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b1, ADD3, 32'h200, 1'b0, 1'b1);
        check("post_rst_rd", 80'(a_rd), 80'd3);
        check("post_rst_valid", 80'(a_valid), 80'd1);

        pcv = 32'h1000;
        cur = rand_inst();
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 9) != 0);
            if (!hold) cur = rand_inst();
            step(v, cur, pcv, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
            hold = v && !m_rdy[0];
            if (!hold) pcv = pcv + 32'd4;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
